// File: rtl/gauss_sink_pkg.sv
// ============================================================================
//  Module      : gauss_sink_pkg
//  Description : Shared widths, types and the normalise/saturate helper for
//                the Gaussian result sink.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package gauss_sink_pkg;

    localparam int PIX_W   = 8;
    localparam int RES_W   = 32;
    localparam int COORD_W = 16;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Returns {sat_flag, pixel}. The sum is widened by one bit so adding the
    // rounding constant to 0xFFFFFFFF cannot wrap.
    function automatic logic [PIX_W:0] sat_norm(input logic [RES_W-1:0] data,
                                                input int               shift);
        logic [RES_W:0] t;
        t = ({1'b0, data} + ({{RES_W{1'b0}}, 1'b1} << (shift - 1))) >> shift;
        if (t[RES_W:PIX_W] != '0)
            return {1'b1, {PIX_W{1'b1}}};
        else
            return {1'b0, t[PIX_W-1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gauss_sink_fifo2.sv
// ============================================================================
//  Module      : gauss_sink_fifo2
//  Description : Generic 2-entry FIFO; pushes while full and pops while empty
//                are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gauss_sink_fifo2
    import gauss_sink_pkg::*;
#(
    parameter int DW = RES_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            if (w_push && !w_pop)
                r_count <= r_count + 2'd1;
            else if (w_pop && !w_push)
                r_count <= r_count - 2'd1;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/gauss_result_sink.sv
// ============================================================================
//  Module      : gauss_result_sink
//  Description : Buffers filter results, normalises/saturates them to 8 bits
//                and tags them with raster coordinates and frame markers.
//                GAUSS_SINK_STATS_EN adds the o_sat_cnt saturation counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gauss_result_sink
    import gauss_sink_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int SHIFT  = 4,
    parameter int CW     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_result_vld,
    input  logic [RES_W-1:0] i_result_data,
    output logic             o_result_busy,
    output logic             o_pix_vld,
    output logic [PIX_W-1:0] o_pix_data,
    output logic [CW-1:0]    o_pix_x,
    output logic [CW-1:0]    o_pix_y,
    output logic             o_pix_eol,
    output logic             o_pix_eof,
    input  logic             i_pix_busy,
    output logic             o_frame_done
`ifdef GAUSS_SINK_STATS_EN
    ,
    output logic [15:0]      o_sat_cnt
`endif
);

    localparam logic [CW-1:0] C_X_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_Y_LAST = CW'(HEIGHT - 1);

    logic [RES_W-1:0] w_fifo_data;
    logic [1:0]       w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_load;
    logic             w_xfer;
    logic [PIX_W:0]   w_norm;
    state_t           r_state;
    state_t           w_state_nxt;

    logic [PIX_W-1:0] r_pix_data;
    logic [CW-1:0]    r_pix_x;
    logic [CW-1:0]    r_pix_y;
    logic             r_pix_eol;
    logic             r_pix_eof;
    logic             r_frame_done;
    logic [CW-1:0]    r_x;
    logic [CW-1:0]    r_y;

    assign w_push = i_result_vld && !w_fifo_full;
    assign w_xfer = o_pix_vld && !i_pix_busy;
    assign w_norm = sat_norm(w_fifo_data, SHIFT);

    gauss_sink_fifo2 #(.DW(RES_W)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_result_data),
        .i_pop   (w_load),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The FIFO count is itself a register, so this decode is glitch-free.
    assign o_result_busy = (w_fifo_count == 2'd2);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT, ST_HOLD: begin
                if (i_pix_busy) begin
                    w_state_nxt = ST_HOLD;
                end else if (!w_fifo_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pix_data   <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_eol    <= 1'b0;
            r_pix_eof    <= 1'b0;
            r_frame_done <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
        end else begin
            r_frame_done <= w_xfer && r_pix_eof;
            if (w_load) begin
                r_pix_data <= w_norm[PIX_W-1:0];
                r_pix_x    <= r_x;
                r_pix_y    <= r_y;
                r_pix_eol  <= (r_x == C_X_LAST);
                r_pix_eof  <= (r_x == C_X_LAST) && (r_y == C_Y_LAST);
                if (r_x == C_X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == C_Y_LAST) ? '0 : r_y + CW'(1);
                end else begin
                    r_x <= r_x + CW'(1);
                end
            end
        end
    end

    assign o_pix_vld    = (r_state != ST_IDLE);
    assign o_pix_data   = r_pix_data;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_pix_eol    = r_pix_eol;
    assign o_pix_eof    = r_pix_eof;
    assign o_frame_done = r_frame_done;

`ifdef GAUSS_SINK_STATS_EN
    logic [15:0] r_sat_cnt;
    logic        r_sat_carry;
    logic        w_sat_hit;
    logic        w_eof_xfer;

    assign w_sat_hit  = w_load && w_norm[PIX_W];
    assign w_eof_xfer = w_xfer && r_pix_eof;

    // A next-frame pixel loaded on the eof edge is parked in r_sat_carry so the
    // done-pulse cycle still shows the finished frame's count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sat_cnt   <= '0;
            r_sat_carry <= 1'b0;
        end else begin
            r_sat_carry <= w_eof_xfer && w_sat_hit;
            if (r_frame_done)
                r_sat_cnt <= 16'(r_sat_carry) + 16'(w_sat_hit);
            else if (w_sat_hit && !w_eof_xfer && (r_sat_cnt != 16'hFFFF))
                r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign o_sat_cnt = r_sat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gauss_result_sink.sv
// ============================================================================
//  Module      : tb_gauss_result_sink
//  Description : Self-checking bench for gauss_result_sink (WIDTH=4, HEIGHT=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gauss_result_sink;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int SHIFT  = 4;
    localparam int CW     = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_result_vld = 1'b0;
    logic [31:0]   i_result_data = '0;
    logic          i_pix_busy = 1'b0;
    logic          o_result_busy;
    logic          o_pix_vld;
    logic [7:0]    o_pix_data;
    logic [CW-1:0] o_pix_x;
    logic [CW-1:0] o_pix_y;
    logic          o_pix_eol;
    logic          o_pix_eof;
    logic          o_frame_done;
`ifdef GAUSS_SINK_STATS_EN
    logic [15:0]   o_sat_cnt;
`endif

    gauss_result_sink #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SHIFT(SHIFT), .CW(CW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_result_vld  (i_result_vld),
        .i_result_data (i_result_data),
        .o_result_busy (o_result_busy),
        .o_pix_vld     (o_pix_vld),
        .o_pix_data    (o_pix_data),
        .o_pix_x       (o_pix_x),
        .o_pix_y       (o_pix_y),
        .o_pix_eol     (o_pix_eol),
        .o_pix_eof     (o_pix_eof),
        .i_pix_busy    (i_pix_busy),
        .o_frame_done  (o_frame_done)
`ifdef GAUSS_SINK_STATS_EN
        ,
        .o_sat_cnt     (o_sat_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] ref_norm(input logic [31:0] d);
        logic [32:0] t;
        t = ({1'b0, d} + (33'd1 << (SHIFT - 1))) >> SHIFT;
        return (t > 33'd255) ? 8'hFF : t[7:0];
    endfunction

    // Scoreboard: every accepted word is expected out in order with raster coordinates.
    logic [7:0]    exp_q[$];
    logic [CW-1:0] mx = '0;
    logic [CW-1:0] my = '0;
    bit            fd_exp = 1'b0;
    bit            hold_prev = 1'b0;

    always @(negedge i_clk) begin
        bit eol_e, eof_e, fd_nxt;
        if (!i_rst) begin
            exp_q.delete();
            mx = '0;
            my = '0;
            fd_exp = 1'b0;
            hold_prev = 1'b0;
        end else begin
            chk("mon_frame_done", o_frame_done, fd_exp);
            if (hold_prev)
                chk("mon_hold_vld", o_pix_vld, 1'b1);
            fd_nxt = 1'b0;
            if (o_pix_vld) begin
                chk("mon_pix_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    eol_e = (mx == CW'(WIDTH - 1));
                    eof_e = eol_e && (my == CW'(HEIGHT - 1));
                    chk("mon_data", o_pix_data, exp_q[0]);
                    chk("mon_x", o_pix_x, mx);
                    chk("mon_y", o_pix_y, my);
                    chk("mon_eol", o_pix_eol, eol_e);
                    chk("mon_eof", o_pix_eof, eof_e);
                    if (!i_pix_busy) begin
                        void'(exp_q.pop_front());
                        fd_nxt = eof_e;
                        if (eol_e) begin
                            mx = '0;
                            my = eof_e ? '0 : my + CW'(1);
                        end else begin
                            mx = mx + CW'(1);
                        end
                    end
                end
            end
            hold_prev = o_pix_vld && i_pix_busy;
            fd_exp = fd_nxt;
            if (i_result_vld && !o_result_busy)
                exp_q.push_back(ref_norm(i_result_data));
        end
    end

    typedef struct {
        logic [31:0] din;
        logic [7:0]  dout;
        logic [15:0] sat;
    } vec_t;

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_pix_vld) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        bit   ok;
        int   first, last, nv, nfd, fd_at, np, k, sent, cyc;
        bit   busy_seen, acc_now;
        logic [CW-1:0] x9, y9, x10, y10;

        tbl[0] = '{32'd0,        8'd0,   16'd0};
        tbl[1] = '{32'd7,        8'd0,   16'd0};
        tbl[2] = '{32'd8,        8'd1,   16'd0};
        tbl[3] = '{32'd4072,     8'd255, 16'd0};
        tbl[4] = '{32'd4080,     8'd255, 16'd0};
        tbl[5] = '{32'd4087,     8'd255, 16'd0};
        tbl[6] = '{32'd4088,     8'd255, 16'd1};
        tbl[7] = '{32'hFFFFFFFF, 8'd255, 16'd2};

        // Reset state
        i_rst = 1'b0;
        repeat (2) tick();
        chk("rst_vld", o_pix_vld, 1'b0);
        chk("rst_busy", o_result_busy, 1'b0);
        chk("rst_frame_done", o_frame_done, 1'b0);
        chk("rst_data", o_pix_data, 8'd0);
        chk("rst_x", o_pix_x, '0);
        chk("rst_y", o_pix_y, '0);
        chk("rst_eol", o_pix_eol, 1'b0);
        chk("rst_eof", o_pix_eof, 1'b0);
        i_rst = 1'b1;
        tick();

        // Normalisation table; the 8 vectors make exactly one frame
        for (int i = 0; i < 8; i++) begin
            i_result_vld  = 1'b1;
            i_result_data = tbl[i].din;
            tick();
            i_result_vld = 1'b0;
            wait_vld(ok);
            chk("norm_vld_seen", ok, 1'b1);
            chk("norm_data", o_pix_data, tbl[i].dout);
`ifdef GAUSS_SINK_STATS_EN
            chk("norm_sat_cnt", o_sat_cnt, tbl[i].sat);
`endif
        end
        tick();
        chk("norm_frame_done", o_frame_done, 1'b1);
`ifdef GAUSS_SINK_STATS_EN
        chk("sat_cnt_on_pulse", o_sat_cnt, 16'd2);
`endif
        tick();
        chk("norm_frame_done_off", o_frame_done, 1'b0);
`ifdef GAUSS_SINK_STATS_EN
        chk("sat_cnt_cleared", o_sat_cnt, 16'd0);
`endif

        // Full-throughput frame
        first = -1; last = -1; nv = 0; nfd = 0; fd_at = -1; busy_seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                i_result_vld  = 1'b1;
                i_result_data = 32'(16 * (c + 1));
            end else begin
                i_result_vld = 1'b0;
            end
            tick();
            if (o_result_busy) busy_seen = 1'b1;
            if (o_pix_vld) begin
                nv++;
                if (first < 0) first = c;
                last = c;
            end
            if (o_frame_done) begin
                nfd++;
                fd_at = c;
            end
        end
        chk("thr_latency", first, 1);
        chk("thr_count", nv, 8);
        chk("thr_contiguous", last - first, 7);
        chk("thr_busy_never", busy_seen, 1'b0);
        chk("thr_frame_done_once", nfd, 1);
        chk("thr_frame_done_pos", fd_at - last, 1);

        // Back-pressure: three words fill output register and FIFO
        i_pix_busy = 1'b1;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            i_result_vld  = 1'b1;
            i_result_data = 32'h100 * (k + 1);
            acc_now = !o_result_busy;
            tick();
            if (acc_now) k++;
        end
        chk("bp_accepted", k, 3);
        chk("bp_busy", o_result_busy, 1'b1);
        chk("bp_vld", o_pix_vld, 1'b1);
        chk("bp_data", o_pix_data, 8'h10);
        i_pix_busy    = 1'b0;
        i_result_data = 32'h100 * (k + 1);
        acc_now = !o_result_busy;
        tick();
        if (acc_now) k++;
        chk("bp_release_busy", o_result_busy, 1'b0);
        for (int c = 0; c < 20 && k < 6; c++) begin
            i_result_vld  = 1'b1;
            i_result_data = 32'h100 * (k + 1);
            acc_now = !o_result_busy;
            tick();
            if (acc_now) k++;
        end
        i_result_vld = 1'b0;
        chk("bp_total", k, 6);
        repeat (10) tick();
        chk("bp_drained_q", exp_q.size(), 0);
        chk("bp_drained_vld", o_pix_vld, 1'b0);

        // Frame wrap: 10 pixels into an 8-pixel frame
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        np = 0; nfd = 0; x9 = '1; y9 = '1; x10 = '1; y10 = '1;
        for (int c = 0; c < 16; c++) begin
            if (c < 10) begin
                i_result_vld  = 1'b1;
                i_result_data = 32'(16 * (c + 1));
            end else begin
                i_result_vld = 1'b0;
            end
            tick();
            if (o_pix_vld) begin
                np++;
                if (np == 9)  begin x9  = o_pix_x; y9  = o_pix_y; end
                if (np == 10) begin x10 = o_pix_x; y10 = o_pix_y; end
            end
            if (o_frame_done) nfd++;
        end
        chk("wrap_count", np, 10);
        chk("wrap_x9", x9, '0);
        chk("wrap_y9", y9, '0);
        chk("wrap_x10", x10, CW'(1));
        chk("wrap_y10", y10, '0);
        chk("wrap_frame_done_once", nfd, 1);

        // Reset mid-stream with FIFO full and output held
        i_pix_busy = 1'b1;
        for (int c = 0; c < 6 && !o_result_busy; c++) begin
            i_result_vld  = 1'b1;
            i_result_data = 32'h333;
            tick();
        end
        i_result_vld = 1'b0;
        chk("mrst_pre_busy", o_result_busy, 1'b1);
        chk("mrst_pre_vld", o_pix_vld, 1'b1);
        i_rst = 1'b0;
        #1;
        chk("mrst_vld", o_pix_vld, 1'b0);
        chk("mrst_busy", o_result_busy, 1'b0);
        chk("mrst_data", o_pix_data, 8'd0);
        chk("mrst_x", o_pix_x, '0);
        chk("mrst_y", o_pix_y, '0);
        chk("mrst_eol_eof", {o_pix_eol, o_pix_eof, o_frame_done}, 3'b000);
        i_pix_busy = 1'b0;
        tick();
        i_rst = 1'b1;
        i_result_vld  = 1'b1;
        i_result_data = 32'h50;
        tick();
        i_result_vld = 1'b0;
        wait_vld(ok);
        chk("mrst_post_vld", ok, 1'b1);
        chk("mrst_post_data", o_pix_data, 8'd5);
        chk("mrst_post_x", o_pix_x, '0);
        chk("mrst_post_y", o_pix_y, '0);
        tick();

        // Random handshake toggling against the scoreboard
        sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!i_result_vld) begin
                i_result_vld = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 2))
                    0:       i_result_data = 32'($urandom_range(0, 4095));
                    1:       i_result_data = 32'($urandom_range(4000, 4200));
                    default: i_result_data = $urandom;
                endcase
            end
            i_pix_busy = ($urandom_range(0, 3) == 0);
            acc_now = i_result_vld && !o_result_busy;
            tick();
            cyc++;
            if (acc_now) begin
                sent++;
                i_result_vld = 1'b0;
            end
        end
        i_result_vld = 1'b0;
        i_pix_busy   = 1'b0;
        chk("rand_sent", sent, 1000);
        repeat (10) tick();
        chk("rand_drained_q", exp_q.size(), 0);
        chk("rand_drained_vld", o_pix_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
